pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//  Generic parametrised inter-stage pipeline register for the five-stage CPU.
//  Carries a control bundle and a data bundle between stages using a valid/ready handshake.
//  Provides an optional 2-entry skid buffer so in_ready is fully registered, plus a synchronous flush.
//  Zeroes control fields on bubbles and counts bubble cycles for performance analysis.
// PARAMETERS
//  CTRL_W          8    width of control bundle (RegWrite/MemRead/MemWrite/...); zeroed on bubble
//  DATA_W          128  width of data bundle (operands, imm, pc+4, funct, shamt, ...)
//  SKID            1    1: 2-entry skid buffer, registered in_ready; 0: single register, combinational in_ready
//  FLUSH_KEEP_DATA 1    1: flush leaves data regs unchanged; 0: flush zeroes data regs
//  CNT_W           16   width of bubble counter
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        asynchronous reset, active-low (0 = reset)
//  in_valid   in   1        upstream beat valid
//  in_ready   out  1        stage can accept a beat
//  in_ctrl    in   CTRL_W   upstream control bundle
//  in_data    in   DATA_W   upstream data bundle
//  flush      in   1        synchronous kill of all held and incoming beats
//  out_valid  out  1        downstream beat valid
//  out_ready  in   1        downstream accepts
//  out_ctrl   out  CTRL_W   control bundle; all-zero when out_valid=0
//  out_data   out  DATA_W   data bundle (don't-care when out_valid=0)
//  occupancy  out  2        beats held: 0, 1 or 2 (max 1 when SKID=0)
//  cnt_clr    in   1        synchronous clear of bubble_cnt
//  bubble_cnt out  CNT_W    saturating count of cycles with out_ready=1 and out_valid=0
// BEHAVIOUR
//  Reset (rst=0, async): M/S valid=0, ctrl and data regs=0, bubble_cnt=0;
//   out_valid=0, out_ctrl=0, occupancy=0, in_ready=1 when SKID=1.
//  Storage: main reg M drives the outputs; skid reg S exists only when SKID=1.
//  Accept: in_valid & in_ready. Emit: out_valid & out_ready. Latency in->out is 1 cycle; order is FIFO.
//  SKID=1:
//   - in_ready = ~S_valid (registered).
//   - Accept while M is empty, or M emits this cycle: beat -> M.
//   - Accept while M is full and M does not emit: beat -> S.
//   - M emits while S is full: S -> M, S empties, in_ready=1 next cycle.
//   - Simultaneous accept + emit with S full cannot occur (in_ready=0).
//  SKID=0:
//   - in_ready = out_ready | ~M_valid (combinational); accept loads M.
//   - Emit without accept clears M_valid.
//  Flush (sync, highest priority):
//   - Next cycle M_valid=S_valid=0 and ctrl regs=0.
//   - A beat accepted in the flush cycle is dropped.
//   - Data regs are held if FLUSH_KEEP_DATA=1, zeroed otherwise.
//   - in_ready follows the normal rule during flush.
//  out_ctrl = M_valid ? M_ctrl : 0, so a bubble never writes the regfile or memory.
//  occupancy = M_valid + S_valid.
//  bubble_cnt:
//   - +1 per cycle with out_ready & ~out_valid; saturates at 2^CNT_W-1.
//   - cnt_clr=1 loads 0; cnt_clr has priority over increment. Not affected by flush.
//  Reset mid-stream: all held beats are lost immediately; no output glitches to nonzero ctrl.
// TESTING
//  1 Reset, then in_valid=1 with ctrl=0x5A/data=D1, out_ready=1 -> out_valid=1, ctrl=0x5A next cycle; 1 beat/cycle sustained.
//  2 SKID=1: out_ready=0, push A then B -> occupancy=2, in_ready=0;
//    out_ready=1 -> A then B in order, in_ready=1 the cycle after S drains.
//  3 Occupancy 2 plus flush with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, occupancy=0;
//    data unchanged (KEEP=1) or 0 (KEEP=0).
//  4 out_ready=1, in_valid=0 for 5 cycles -> bubble_cnt=5; cnt_clr with bubble -> 0;
//    CNT_W=4 with 20 bubbles -> 15.
//  5 SKID=0: out_ready=0 with M full -> in_ready=0; out_ready=1 with in_valid -> in_ready=1, back-to-back transfer.
//  6 rst=0 asserted asynchronously mid-burst -> out_valid, out_ctrl and occupancy go 0 before the next clk edge.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised inter-stage pipeline register with a valid/ready
// handshake, an optional 2-entry skid buffer (registered in_ready), a synchronous
// flush, control zeroing on bubbles and a saturating bubble-cycle counter.
module pipe_stage_reg #(
  parameter int CTRL_W          = 8,
  parameter int DATA_W          = 128,
  parameter int SKID            = 1,
  parameter int FLUSH_KEEP_DATA = 1,
  parameter int CNT_W           = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam bit HAS_SKID  = (SKID != 0);
  localparam bit KEEP_DATA = (FLUSH_KEEP_DATA != 0);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Main register M (drives outputs) and skid register S (used only with SKID=1)
  logic              m_valid_r, s_valid_r;
  logic [CTRL_W-1:0] m_ctrl_r,  s_ctrl_r;
  logic [DATA_W-1:0] m_data_r,  s_data_r;

  logic              m_valid_s, s_valid_s;
  logic [CTRL_W-1:0] m_ctrl_s,  s_ctrl_s;
  logic [DATA_W-1:0] m_data_s,  s_data_s;

  logic              accept_s;
  logic              emit_s;
  logic [CNT_W-1:0]  bubble_cnt_r;

  // With a skid buffer in_ready depends only on S state, so it is a flop output;
  // without one, a full M can still accept if it is emitting this cycle.
  assign in_ready = HAS_SKID ? ~s_valid_r : (out_ready | ~m_valid_r);
  assign accept_s = in_valid & in_ready;
  assign emit_s   = m_valid_r & out_ready;

  // Next-state selection for M and S; flush overrides every other transition.
  always_comb begin
    m_valid_s = m_valid_r;
    s_valid_s = s_valid_r;
    m_ctrl_s  = m_ctrl_r;
    s_ctrl_s  = s_ctrl_r;
    m_data_s  = m_data_r;
    s_data_s  = s_data_r;
    if (flush) begin
      m_valid_s = 1'b0;
      s_valid_s = 1'b0;
      m_ctrl_s  = {CTRL_W{1'b0}};
      s_ctrl_s  = {CTRL_W{1'b0}};
      if (KEEP_DATA) begin
        m_data_s = m_data_r;
        s_data_s = s_data_r;
      end else begin
        m_data_s = {DATA_W{1'b0}};
        s_data_s = {DATA_W{1'b0}};
      end
    end else if (HAS_SKID) begin
      if (!m_valid_r || emit_s) begin
        if (s_valid_r) begin
          // S refills M; in_ready was low so no new beat arrives this cycle
          m_valid_s = 1'b1;
          m_ctrl_s  = s_ctrl_r;
          m_data_s  = s_data_r;
          s_valid_s = 1'b0;
          s_ctrl_s  = {CTRL_W{1'b0}};
        end else if (accept_s) begin
          m_valid_s = 1'b1;
          m_ctrl_s  = in_ctrl;
          m_data_s  = in_data;
        end else begin
          m_valid_s = 1'b0;
          m_ctrl_s  = {CTRL_W{1'b0}};
        end
      end else if (accept_s) begin
        // M is stalled: park the incoming beat in S
        s_valid_s = 1'b1;
        s_ctrl_s  = in_ctrl;
        s_data_s  = in_data;
      end else begin
        s_valid_s = s_valid_r;
      end
    end else begin
      if (accept_s) begin
        m_valid_s = 1'b1;
        m_ctrl_s  = in_ctrl;
        m_data_s  = in_data;
      end else if (emit_s) begin
        m_valid_s = 1'b0;
        m_ctrl_s  = {CTRL_W{1'b0}};
      end else begin
        m_valid_s = m_valid_r;
      end
    end
  end

  // Storage registers; asynchronous reset discards every held beat at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid_r <= 1'b0;
      s_valid_r <= 1'b0;
      m_ctrl_r  <= {CTRL_W{1'b0}};
      s_ctrl_r  <= {CTRL_W{1'b0}};
      m_data_r  <= {DATA_W{1'b0}};
      s_data_r  <= {DATA_W{1'b0}};
    end else begin
      m_valid_r <= m_valid_s;
      s_valid_r <= s_valid_s;
      m_ctrl_r  <= m_ctrl_s;
      s_ctrl_r  <= s_ctrl_s;
      m_data_r  <= m_data_s;
      s_data_r  <= s_data_s;
    end
  end

  // Saturating count of downstream-ready cycles with nothing to offer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubble_cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_clr) begin
      bubble_cnt_r <= {CNT_W{1'b0}};
    end else if (out_ready && !m_valid_r && (bubble_cnt_r != CNT_MAX)) begin
      bubble_cnt_r <= bubble_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      bubble_cnt_r <= bubble_cnt_r;
    end
  end

  // Control is gated so a bubble can never write the register file or memory.
  assign out_valid  = m_valid_r;
  assign out_ctrl   = m_valid_r ? m_ctrl_r : {CTRL_W{1'b0}};
  assign out_data   = m_data_r;
  assign occupancy  = {1'b0, m_valid_r} + {1'b0, s_valid_r};
  assign bubble_cnt = bubble_cnt_r;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: instance "a" uses a skid buffer and keeps data on
// flush; instance "b" has no skid buffer, zeroes data on flush and a 4-bit counter.
module tb_pipe_stage_reg;

  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready, a_cnt_clr;
  logic [7:0]    a_in_ctrl, a_out_ctrl;
  logic [DW-1:0] a_in_data, a_out_data;
  logic [1:0]    a_occ;
  logic [15:0]   a_bcnt;

  logic          b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready, b_cnt_clr;
  logic [7:0]    b_in_ctrl, b_out_ctrl;
  logic [DW-1:0] b_in_data, b_out_data;
  logic [1:0]    b_occ;
  logic [3:0]    b_bcnt;

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(DW), .SKID(1), .FLUSH_KEEP_DATA(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_ctrl(a_in_ctrl), .in_data(a_in_data), .flush(a_flush),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ctrl(a_out_ctrl),
    .out_data(a_out_data), .occupancy(a_occ), .cnt_clr(a_cnt_clr), .bubble_cnt(a_bcnt));

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(DW), .SKID(0), .FLUSH_KEEP_DATA(0), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_ctrl(b_in_ctrl), .in_data(b_in_data), .flush(b_flush),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl),
    .out_data(b_out_data), .occupancy(b_occ), .cnt_clr(b_cnt_clr), .bubble_cnt(b_bcnt));

  typedef struct packed {
    logic [7:0]    c;
    logic [DW-1:0] d;
  } beat_t;

  beat_t qa[$];
  beat_t qb[$];
  beat_t sb_a_exp, sb_b_exp;
  int    vectors = 0;
  int    errors  = 0;

  // Scoreboard for instance a: pop on emit, push on accept, drop everything on flush.
  always @(negedge clk) begin
    if (!rst) begin
      qa.delete();
    end else begin
      if (a_out_valid && a_out_ready) begin
        vectors++;
        if (qa.size() == 0) begin
          errors++;
          $display("FAIL sb_a unexpected beat got ctrl=%h data=%h, none expected", a_out_ctrl, a_out_data);
        end else begin
          sb_a_exp = qa.pop_front();
          if ({a_out_ctrl, a_out_data} !== sb_a_exp) begin
            errors++;
            $display("FAIL sb_a got ctrl=%h data=%h want ctrl=%h data=%h",
                     a_out_ctrl, a_out_data, sb_a_exp.c, sb_a_exp.d);
          end
        end
      end
      if (a_in_valid && a_in_ready) qa.push_back({a_in_ctrl, a_in_data});
      if (a_flush) qa.delete();
    end
  end

  // Scoreboard for instance b.
  always @(negedge clk) begin
    if (!rst) begin
      qb.delete();
    end else begin
      if (b_out_valid && b_out_ready) begin
        vectors++;
        if (qb.size() == 0) begin
          errors++;
          $display("FAIL sb_b unexpected beat got ctrl=%h data=%h, none expected", b_out_ctrl, b_out_data);
        end else begin
          sb_b_exp = qb.pop_front();
          if ({b_out_ctrl, b_out_data} !== sb_b_exp) begin
            errors++;
            $display("FAIL sb_b got ctrl=%h data=%h want ctrl=%h data=%h",
                     b_out_ctrl, b_out_data, sb_b_exp.c, sb_b_exp.d);
          end
        end
      end
      if (b_in_valid && b_in_ready) qb.push_back({b_in_ctrl, b_in_data});
      if (b_flush) qb.delete();
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cyc();
    cyc();
    vectors++;
    if ({a_out_valid, a_out_ctrl, a_occ, a_in_ready, a_bcnt} !== {1'b0, 8'h00, 2'd0, 1'b1, 16'h0000}) begin
      errors++;
      $display("FAIL reset_a got v=%b c=%h occ=%0d rdy=%b cnt=%0d want v=0 c=00 occ=0 rdy=1 cnt=0",
               a_out_valid, a_out_ctrl, a_occ, a_in_ready, a_bcnt);
    end
    vectors++;
    if ({b_out_valid, b_out_ctrl, b_occ, b_bcnt} !== {1'b0, 8'h00, 2'd0, 4'h0}) begin
      errors++;
      $display("FAIL reset_b got v=%b c=%h occ=%0d cnt=%0d want 0/00/0/0",
               b_out_valid, b_out_ctrl, b_occ, b_bcnt);
    end
    rst = 1'b1;
    cyc();
  endtask

  task automatic test_stream();
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    a_in_ctrl   = 8'h5A;
    a_in_data   = 32'hD1D1_0001;
    cyc();
    vectors++;
    if ({a_out_valid, a_out_ctrl, a_out_data} !== {1'b1, 8'h5A, 32'hD1D1_0001}) begin
      errors++;
      $display("FAIL first_beat got v=%b c=%h d=%h want v=1 c=5a d=d1d10001",
               a_out_valid, a_out_ctrl, a_out_data);
    end
    for (int i = 0; i < 8; i++) begin
      a_in_ctrl = 8'($urandom);
      a_in_data = 32'($urandom);
      cyc();
      vectors++;
      if ({a_out_valid, a_in_ready, a_occ} !== {1'b1, 1'b1, 2'd1}) begin
        errors++;
        $display("FAIL sustained[%0d] got v=%b rdy=%b occ=%0d want 1/1/1", i, a_out_valid, a_in_ready, a_occ);
      end
    end
    a_in_valid = 1'b0;
    cyc();
    vectors++;
    if ({a_out_valid, a_out_ctrl} !== {1'b0, 8'h00}) begin
      errors++;
      $display("FAIL stream_drain got v=%b c=%h want 0/00", a_out_valid, a_out_ctrl);
    end
  endtask

  task automatic test_skid();
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_ctrl   = 8'hA1;
    a_in_data   = 32'hAAAA_0001;
    cyc();
    a_in_ctrl   = 8'hB2;
    a_in_data   = 32'hBBBB_0002;
    cyc();
    a_in_valid  = 1'b0;
    vectors++;
    if ({a_occ, a_in_ready, a_out_ctrl} !== {2'd2, 1'b0, 8'hA1}) begin
      errors++;
      $display("FAIL skid_full got occ=%0d rdy=%b c=%h want 2/0/a1", a_occ, a_in_ready, a_out_ctrl);
    end
    a_out_ready = 1'b1;
    cyc();
    vectors++;
    if ({a_out_ctrl, a_occ, a_in_ready} !== {8'hB2, 2'd1, 1'b1}) begin
      errors++;
      $display("FAIL skid_drain got c=%h occ=%0d rdy=%b want b2/1/1", a_out_ctrl, a_occ, a_in_ready);
    end
    cyc();
    vectors++;
    if ({a_out_valid, a_out_ctrl, a_occ} !== {1'b0, 8'h00, 2'd0}) begin
      errors++;
      $display("FAIL skid_empty got v=%b c=%h occ=%0d want 0/00/0", a_out_valid, a_out_ctrl, a_occ);
    end
  endtask

  task automatic test_flush();
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_ctrl   = 8'hC3;
    a_in_data   = 32'hCCCC_0003;
    cyc();
    a_in_ctrl   = 8'hD4;
    a_in_data   = 32'hDDDD_0004;
    cyc();
    a_in_ctrl   = 8'hE5;
    a_in_data   = 32'hEEEE_0005;
    a_flush     = 1'b1;
    cyc();
    a_flush     = 1'b0;
    a_in_valid  = 1'b0;
    vectors++;
    if ({a_out_valid, a_out_ctrl, a_occ, a_out_data} !== {1'b0, 8'h00, 2'd0, 32'hCCCC_0003}) begin
      errors++;
      $display("FAIL flush_keep got v=%b c=%h occ=%0d d=%h want 0/00/0/cccc0003",
               a_out_valid, a_out_ctrl, a_occ, a_out_data);
    end
    b_out_ready = 1'b0;
    b_in_valid  = 1'b1;
    b_in_ctrl   = 8'h77;
    b_in_data   = 32'h7777_0007;
    cyc();
    b_flush     = 1'b1;
    cyc();
    b_flush     = 1'b0;
    b_in_valid  = 1'b0;
    vectors++;
    if ({b_out_valid, b_out_ctrl, b_occ, b_out_data} !== {1'b0, 8'h00, 2'd0, 32'h0000_0000}) begin
      errors++;
      $display("FAIL flush_zero got v=%b c=%h occ=%0d d=%h want 0/00/0/00000000",
               b_out_valid, b_out_ctrl, b_occ, b_out_data);
    end
  endtask

  task automatic test_bubble();
    a_out_ready = 1'b1;
    a_cnt_clr   = 1'b1;
    cyc();
    a_cnt_clr   = 1'b0;
    repeat (5) cyc();
    vectors++;
    if (a_bcnt !== 16'd5) begin
      errors++;
      $display("FAIL bubble5 got %0d want 5", a_bcnt);
    end
    a_cnt_clr = 1'b1;
    cyc();
    a_cnt_clr = 1'b0;
    vectors++;
    if (a_bcnt !== 16'd0) begin
      errors++;
      $display("FAIL bubble_clr got %0d want 0", a_bcnt);
    end
    b_out_ready = 1'b1;
    b_cnt_clr   = 1'b1;
    cyc();
    b_cnt_clr   = 1'b0;
    repeat (14) cyc();
    vectors++;
    if (b_bcnt !== 4'd14) begin
      errors++;
      $display("FAIL bubble14 got %0d want 14", b_bcnt);
    end
    repeat (6) cyc();
    vectors++;
    if (b_bcnt !== 4'd15) begin
      errors++;
      $display("FAIL bubble_sat got %0d want 15", b_bcnt);
    end
  endtask

  task automatic test_back_to_back();
    b_out_ready = 1'b0;
    b_in_valid  = 1'b1;
    b_in_ctrl   = 8'h11;
    b_in_data   = 32'h1111_0011;
    cyc();
    vectors++;
    if ({b_in_ready, b_occ} !== {1'b0, 2'd1}) begin
      errors++;
      $display("FAIL noskid_stall got rdy=%b occ=%0d want 0/1", b_in_ready, b_occ);
    end
    b_out_ready = 1'b1;
    b_in_ctrl   = 8'h22;
    b_in_data   = 32'h2222_0022;
    #1;
    vectors++;
    if (b_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL noskid_comb_ready got %b want 1", b_in_ready);
    end
    for (int i = 0; i < 6; i++) begin
      cyc();
      vectors++;
      if ({b_out_valid, b_in_ready} !== {1'b1, 1'b1}) begin
        errors++;
        $display("FAIL noskid_b2b[%0d] got v=%b rdy=%b want 1/1", i, b_out_valid, b_in_ready);
      end
      b_in_ctrl = 8'($urandom);
      b_in_data = 32'($urandom);
    end
    b_in_valid = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic test_async_reset();
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_ctrl   = 8'h99;
    a_in_data   = 32'h9999_0009;
    b_out_ready = 1'b0;
    b_in_valid  = 1'b1;
    b_in_ctrl   = 8'h88;
    b_in_data   = 32'h8888_0008;
    cyc();
    a_in_ctrl   = 8'h9A;
    cyc();
    a_in_valid  = 1'b0;
    b_in_valid  = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    vectors++;
    if ({a_out_valid, a_out_ctrl, a_occ} !== {1'b0, 8'h00, 2'd0}) begin
      errors++;
      $display("FAIL async_rst_a got v=%b c=%h occ=%0d want 0/00/0", a_out_valid, a_out_ctrl, a_occ);
    end
    vectors++;
    if ({b_out_valid, b_out_ctrl, b_occ} !== {1'b0, 8'h00, 2'd0}) begin
      errors++;
      $display("FAIL async_rst_b got v=%b c=%h occ=%0d want 0/00/0", b_out_valid, b_out_ctrl, b_occ);
    end
    cyc();
    rst = 1'b1;
    cyc();
  endtask

  initial begin
    rst = 1'b0;
    a_in_valid = 1'b0; a_in_ctrl = 8'h00; a_in_data = 32'h0; a_flush = 1'b0;
    a_out_ready = 1'b0; a_cnt_clr = 1'b0;
    b_in_valid = 1'b0; b_in_ctrl = 8'h00; b_in_data = 32'h0; b_flush = 1'b0;
    b_out_ready = 1'b0; b_cnt_clr = 1'b0;
    test_reset();
    test_stream();
    test_skid();
    test_flush();
    test_bubble();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
